// File: rtl/xalu_ise_pkg.sv
// Shared constants and the response-entry layout for the ISE ALU response stage.
// Used by xalu_rsp_fifo and xalu_ise_rsp.
package xalu_ise_pkg;

    localparam int ISE_XLEN  = 64;
    localparam int ISE_TAG_W = 5;

    typedef struct packed {
        logic [ISE_XLEN-1:0]  data;
        logic [ISE_TAG_W-1:0] tag;
        logic                 ill;
    } rsp_entry_t;

    // The FIFO relies on natural pointer wrap, so depth must be a power of two.
    function automatic bit depth_ok(input int unsigned d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/xalu_rsp_fifo.sv
// In-order response FIFO: pointers, occupancy count and storage.
// Flush has priority over push and pop. Storage is never reset.
module xalu_rsp_fifo
    import xalu_ise_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_depth_chk
        $error("xalu_rsp_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic [W-1:0]     r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/xalu_ise_rsp.sv
// ISE ALU response stage: turns each issue into exactly one writeback response.
// Optional zero-latency bypass on an empty FIFO is enabled by XALU_RSP_BYPASS_EN.
module xalu_ise_rsp
    import xalu_ise_pkg::*;
#(
    parameter int XLEN  = ISE_XLEN,
    parameter int TAG_W = ISE_TAG_W,
    parameter int DEPTH = 2
) (
    input  logic             ise_clk,
    input  logic             ise_rst,
    input  logic             ise_flush,
    input  logic             ise_val,
    input  logic [TAG_W-1:0] ise_tag,
    input  logic             ise_oval,
    input  logic [XLEN-1:0]  ise_out,
    output logic             ise_rdy,
    output logic             wb_val,
    output logic [XLEN-1:0]  wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_ill,
    input  logic             wb_rdy
);

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } entry_t;

    entry_t w_entry;
    entry_t w_head;
    entry_t w_rsp;
    logic   w_empty;
    logic   w_full;
    logic   w_push;
    logic   w_pop;

    // An issue the ALU did not claim becomes an illegal-instruction response.
    always_comb begin
        w_entry.data = ise_oval ? ise_out : '0;
        w_entry.tag  = ise_tag;
        w_entry.ill  = ~ise_oval;
    end

    assign ise_rdy = ~w_full;

`ifdef XALU_RSP_BYPASS_EN
    logic w_byp;
    assign w_byp  = w_empty & ise_val & wb_rdy;
    assign w_push = ise_val & ise_rdy & ~ise_flush & ~w_byp;
    assign w_pop  = ~w_empty & wb_rdy & ~ise_flush;
    assign wb_val = (~w_empty | ise_val) & ~ise_flush;
    assign w_rsp  = ~w_empty ? w_head : (ise_val ? w_entry : '0);
`else
    assign w_push = ise_val & ise_rdy & ~ise_flush;
    assign w_pop  = ~w_empty & wb_rdy & ~ise_flush;
    assign wb_val = ~w_empty;
    assign w_rsp  = w_empty ? '0 : w_head;
`endif

    assign wb_data = w_rsp.data;
    assign wb_tag  = w_rsp.tag;
    assign wb_ill  = w_rsp.ill;

    xalu_rsp_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (ise_clk),
        .rst_n   (ise_rst),
        .i_flush (ise_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_entry),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

endmodule
